cu_datapath: RTL

- Executes the 32-bit one-hot control word that the microprogrammed control unit issues every cycle.
- Holds the architectural registers PC, MAR, MBR, IR, ACC, BR and MR, plus the ALU, a multi-cycle multiplier and the flag register.
- Drives the 256x16 main-memory port.
- Returns the latched opcode and the flags to the control unit, closing the control-word loop.

---
 rtl/cu_datapath.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/cu_datapath.sv
// cu_datapath: executes the one-hot control word issued every cycle by the
// microprogrammed control unit. Holds PC, MAR, MBR, IR, ACC, BR and MR, the
// ALU, a multi-cycle unsigned shift-add multiplier and the flag register, and
// drives the main-memory port.
//
// Ports:
//   clk            system clock, rising-edge active
//   rst            asynchronous active-high reset
//   control_signal one-hot-per-function control word
//   mem_rdata      RAM read data for mem_addr (combinational)
//   mem_addr       MAR
//   mem_wdata      MBR
//   mem_we         registered one-cycle write strobe
//   data_from_ir   opcode latched from IR on ir2cu
//   flags          {3'b0, busy_violation, V, C, Z, N}
//   busy           multiplier running
module cu_datapath #(
    parameter int DW         = 16,
    parameter int AW         = 8,
    parameter int MPY_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   control_signal,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [AW-1:0] data_from_ir,
    output logic [7:0]    flags,
    output logic          busy
);

    // Bits that are dropped (and flagged) while the multiplier runs:
    // 1-6, 8, 10-16, 20-31.
    localparam logic [31:0] BUSY_MASK = 32'hFFF1_FD7E;
    localparam int          CW_W      = $clog2(MPY_CYCLES + 1);

    typedef enum logic {
        MPY_IDLE,
        MPY_RUN
    } mpy_state_t;

    mpy_state_t      mstate;
    logic [CW_W-1:0] mcnt;
    logic [DW-1:0]   mcand;
    logic [2*DW-1:0] prod;

    logic [AW-1:0]   pc, mar, ir, dfi;
    logic [DW-1:0]   mbr, acc, br, mr;
    logic            flag_n, flag_z, flag_c, flag_v, flag_viol, we;

    logic [31:0]     cw;
    logic [DW:0]     sum, diff, step_add;
    logic [2*DW-1:0] prod_next;
    logic [DW-1:0]   alu_res;
    logic            alu_c, alu_v, alu_valid, mpy_req;
    logic            ctrl_unused;

    assign busy         = (mstate == MPY_RUN);
    assign mem_addr     = mar;
    assign mem_wdata    = mbr;
    assign mem_we       = we;
    assign data_from_ir = dfi;
    assign flags        = {3'b000, flag_viol, flag_v, flag_c, flag_z, flag_n};

    // No-op / CU-internal bits carry no datapath action.
    assign ctrl_unused = ^{cw[0], cw[7], cw[9], cw[14], cw[19:17]};

    always_comb begin
        cw = busy ? (control_signal & ~BUSY_MASK) : control_signal;
    end

    // ALU: lowest-index op bit among 22-31 wins.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, br};
        diff      = {1'b0, acc} - {1'b0, br};
        alu_res   = '0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_valid = 1'b0;
        mpy_req   = 1'b0;
        if (cw[22]) begin
            alu_res   = sum[DW-1:0];
            alu_c     = sum[DW];
            alu_v     = (acc[DW-1] == br[DW-1]) && (sum[DW-1] != acc[DW-1]);
            alu_valid = 1'b1;
        end else if (cw[23]) begin
            alu_res   = diff[DW-1:0];
            alu_c     = diff[DW];
            alu_v     = (acc[DW-1] != br[DW-1]) && (diff[DW-1] != acc[DW-1]);
            alu_valid = 1'b1;
        end else if (cw[24]) begin
            alu_res   = acc & br;
            alu_valid = 1'b1;
        end else if (cw[25]) begin
            alu_res   = acc | br;
            alu_valid = 1'b1;
        end else if (cw[26]) begin
            alu_res   = ~br;
            alu_valid = 1'b1;
        end else if (cw[27]) begin
            alu_res   = {acc[DW-2:0], 1'b0};
            alu_c     = acc[DW-1];
            alu_valid = 1'b1;
        end else if (cw[28]) begin
            alu_res   = {1'b0, acc[DW-1:1]};
            alu_c     = acc[0];
            alu_valid = 1'b1;
        end else if (cw[29]) begin
            mpy_req   = 1'b1;
        end else if (cw[30]) begin
            alu_res   = {acc[DW-2:0], 1'b0};
            alu_c     = acc[DW-1];
            alu_v     = acc[DW-1] ^ acc[DW-2];
            alu_valid = 1'b1;
        end else if (cw[31]) begin
            alu_res   = {acc[DW-1], acc[DW-1:1]};
            alu_c     = acc[0];
            alu_valid = 1'b1;
        end
    end

    // One shift-add step: high half accumulates the multiplicand when the
    // current multiplier bit (prod[0]) is set, then the whole product shifts right.
    always_comb begin
        step_add  = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_next = {step_add, prod[DW-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= '0;
            mar       <= '0;
            mbr       <= '0;
            ir        <= '0;
            dfi       <= '0;
            acc       <= '0;
            br        <= '0;
            mr        <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
            flag_viol <= 1'b0;
            we        <= 1'b0;
            mstate    <= MPY_IDLE;
            mcnt      <= '0;
            mcand     <= '0;
            prod      <= '0;
        end else begin
            we <= cw[12];

            if (busy && (|(control_signal & BUSY_MASK)))
                flag_viol <= 1'b1;

            if (cw[5])       mbr <= mem_rdata;
            else if (cw[16]) mbr <= acc;
            else if (cw[15]) mbr <= mr;
            else if (cw[11]) mbr <= acc;
            else if (cw[1])  mbr <= {{(DW-AW){1'b0}}, pc};

            if (cw[3])       pc <= mbr[AW-1:0];
            else if (cw[20]) pc <= pc + 1'b1;

            if (cw[8])       mar <= mbr[AW-1:0];
            else if (cw[2])  mar <= pc;

            if (cw[4])  ir  <= mbr[DW-1:DW-AW];
            if (cw[6])  br  <= mbr;
            if (cw[13]) dfi <= ir;

            if (cw[21]) begin
                acc    <= '0;
                flag_n <= 1'b0;
                flag_z <= 1'b1;
            end else if (cw[10]) begin
                acc    <= mbr;
                flag_n <= mbr[DW-1];
            end else if (alu_valid) begin
                acc    <= alu_res;
                flag_n <= alu_res[DW-1];
                flag_z <= (alu_res == '0);
                flag_c <= alu_c;
                flag_v <= alu_v;
            end else if (mpy_req && !busy) begin
                mcand  <= acc;
                prod   <= {{DW{1'b0}}, br};
                mcnt   <= CW_W'(MPY_CYCLES);
                mstate <= MPY_RUN;
            end

            // While running, every ACC-writing bit is masked off above, so
            // this is the only ACC/MR writer during a multiply.
            if (mstate == MPY_RUN) begin
                prod <= prod_next;
                mcnt <= mcnt - 1'b1;
                if (mcnt == CW_W'(1)) begin
                    mstate <= MPY_IDLE;
                    mr     <= prod_next[2*DW-1:DW];
                    acc    <= prod_next[DW-1:0];
                    flag_n <= prod_next[DW-1];
                    flag_z <= (prod_next == '0);
                    flag_c <= |prod_next[2*DW-1:DW];
                    flag_v <= |prod_next[2*DW-1:DW];
                end
            end
        end
    end

endmodule
